// File: rtl/tile_stream_pkg.sv
// Shared types and defaults for the tile stream ingress mux.
package tile_stream_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/tile_stream_rr_mux_if.sv
// Kernel-facing AXI-stream bundle of the ingress mux (master = mux side).
interface tile_stream_rr_mux_if #(
  parameter int BW  = 32,
  parameter int BWB = BW / 8,
  parameter int DW  = 2
);
  logic           TVALID;
  logic           TREADY;
  logic [BW-1:0]  TDATA;
  logic [BWB-1:0] TKEEP;
  logic           TLAST;
  logic [DW-1:0]  TDEST;

  modport master (output TVALID, TDATA, TKEEP, TLAST, TDEST, input TREADY);
  modport slave  (input TVALID, TDATA, TKEEP, TLAST, TDEST, output TREADY);
endinterface

// File: rtl/tile_stream_fifo.sv
// Single-clock first-word-fall-through FIFO; head word is valid whenever !empty.
module tile_stream_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_line,
  input  logic         clk_line_rst_low,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the pointers alone decide what is visible.
  always_ff @(posedge clk_line) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/tile_stream_rr_mux.sv
// N-channel buffered ingress with packet-level round-robin merge onto one stream.
//   state  | meaning
//   IDLE   | between packets; picks next armed, enabled, non-empty channel
//   LOCKED | forwarding one packet from grant until its TLAST handshake
module tile_stream_rr_mux
  import tile_stream_pkg::*;
#(
  parameter int BW         = 32,
  parameter int BWB        = BW / 8,
  parameter int N_CH       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = CNT_W_DEFAULT
) (
  input  logic                  clk_line,
  input  logic                  clk_line_rst_low,
  input  logic                  plain_start_of_processing,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH-1:0]       stream_in_TVALID,
  output logic [N_CH-1:0]       stream_in_TREADY,
  input  logic [N_CH-1:0]       stream_in_TLAST,
  input  logic [N_CH*BW-1:0]    stream_in_TDATA,
  input  logic [N_CH*BWB-1:0]   stream_in_TKEEP,
  tile_stream_rr_mux_if.master  stream_out,
  output logic                  busy,
  output logic [N_CH*CNT_W-1:0] pkt_cnt
);
  localparam int GW = $clog2(N_CH);
  localparam int EW = 1 + BWB + BW;

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d, rr_ptr_q, rr_ptr_d, pick;
  logic             arm_q, arm_d, rdy_q, rdy_d;
  logic             pick_vld, out_vld, hs;
  logic [GW:0]      rr_sum;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  full, empty, pop;
  logic [EW-1:0]    head [N_CH];
  logic [EW-1:0]    head_g;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tile_stream_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_line         (clk_line),
      .clk_line_rst_low (clk_line_rst_low),
      .push             (stream_in_TVALID[i] && rdy_q),
      .wdata            ({stream_in_TLAST[i], stream_in_TKEEP[i*BWB +: BWB],
                          stream_in_TDATA[i*BW +: BW]}),
      .pop              (pop[i]),
      .rdata            (head[i]),
      .full             (full[i]),
      .empty            (empty[i])
    );
    assign pkt_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  // Hold TREADY low until the first edge after reset release.
  assign stream_in_TREADY = rdy_q ? ~full : '0;

  assign head_g            = head[grant_q];
  assign out_vld           = (state_q == LOCKED) && !empty[grant_q];
  assign hs                = out_vld && stream_out.TREADY;
  assign pop               = hs ? (N_CH'(1) << grant_q) : '0;
  assign stream_out.TVALID = out_vld;
  assign stream_out.TDATA  = out_vld ? head_g[BW-1:0] : '0;
  assign stream_out.TKEEP  = out_vld ? head_g[BW +: BWB] : '0;
  assign stream_out.TLAST  = out_vld && head_g[EW-1];
  assign stream_out.TDEST  = out_vld ? grant_q : '0;
  assign busy              = (state_q == LOCKED);

  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    rr_sum   = '0;
    for (int k = 0; k < N_CH; k++) begin
      rr_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
      if (rr_sum >= (GW+1)'(N_CH)) rr_sum = rr_sum - (GW+1)'(N_CH);
      if (!pick_vld && !empty[rr_sum[GW-1:0]] && ch_enable[rr_sum[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = rr_sum[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    arm_d    = arm_q || plain_start_of_processing;
    rdy_d    = 1'b1;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (arm_q && pick_vld) begin
          state_d = LOCKED;
          grant_d = pick;
        end
      end
      LOCKED: begin
        if (hs && head_g[EW-1]) begin
          state_d  = IDLE;
          rr_ptr_d = (grant_q == GW'(N_CH - 1)) ? '0 : grant_q + GW'(1);
          if (cnt_q[grant_q] != '1) cnt_d[grant_q] = cnt_q[grant_q] + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      arm_q    <= 1'b0;
      rdy_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      arm_q    <= arm_d;
      rdy_q    <= rdy_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_tile_stream_rr_mux.sv
// Self-checking bench: queue-level reference model compared every cycle, plus directed literal checks.
module tb_tile_stream_rr_mux;
  localparam int N     = 4;
  localparam int BW    = 32;
  localparam int BWB   = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int GW    = 2;
  localparam int MAXC  = 15;

  logic             clk_line  = 1'b0;
  logic             rst_low   = 1'b0;
  logic             start     = 1'b0;
  logic [N-1:0]     en        = '1;
  logic [N-1:0]     in_valid  = '0;
  logic [N-1:0]     in_last   = '0;
  logic [N*BW-1:0]  in_data   = '0;
  logic [N*BWB-1:0] in_keep   = '0;
  logic             out_ready = 1'b1;
  logic [N-1:0]     in_ready;
  logic             busy;
  logic [N*CW-1:0]  pkt_cnt;

  tile_stream_rr_mux_if #(.BW(BW), .BWB(BWB), .DW(GW)) so ();
  assign so.TREADY = out_ready;

  tile_stream_rr_mux #(.BW(BW), .BWB(BWB), .N_CH(N), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk_line                  (clk_line),
    .clk_line_rst_low          (rst_low),
    .plain_start_of_processing (start),
    .ch_enable                 (en),
    .stream_in_TVALID          (in_valid),
    .stream_in_TREADY          (in_ready),
    .stream_in_TLAST           (in_last),
    .stream_in_TDATA           (in_data),
    .stream_in_TKEEP           (in_keep),
    .stream_out                (so),
    .busy                      (busy),
    .pkt_cnt                   (pkt_cnt)
  );

  always #5 clk_line = ~clk_line;

  typedef struct packed {
    logic           last;
    logic [BWB-1:0] keep;
    logic [BW-1:0]  data;
  } word_t;

  typedef struct {
    int            cyc;
    int            dest;
    logic [BW-1:0] data;
    logic          last;
  } hs_t;

  word_t mq [N][$];
  hs_t   hs_log [$];
  bit    m_locked, m_armed, m_rdy;
  int    m_g, m_rr;
  int    m_cnt [N];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_cnt[i] = 0;
    end
    m_locked = 0; m_armed = 0; m_rdy = 0; m_g = 0; m_rr = 0;
  endtask

  task automatic compare();
    bit              v;
    word_t           h;
    logic [N-1:0]    er;
    logic [N*CW-1:0] ec;
    hs_t             e;
    v = m_locked && (mq[m_g].size() > 0);
    h = '0;
    if (v) h = mq[m_g][0];
    for (int i = 0; i < N; i++) begin
      er[i] = m_rdy && (mq[i].size() < DEPTH);
      ec[i*CW +: CW] = CW'(m_cnt[i]);
    end
    chk("in_ready", in_ready, er);
    chk("out_valid", so.TVALID, v);
    chk("out_data", so.TDATA, h.data);
    chk("out_keep", so.TKEEP, h.keep);
    chk("out_last", so.TLAST, h.last);
    chk("out_dest", so.TDEST, v ? GW'(m_g) : '0);
    chk("busy", busy, m_locked);
    chk("pkt_cnt", pkt_cnt, ec);
    if (so.TVALID && out_ready) begin
      e.cyc = cyc; e.dest = int'(so.TDEST); e.data = so.TDATA; e.last = so.TLAST;
      hs_log.push_back(e);
    end
  endtask

  task automatic model_update();
    int    sz [N];
    int    c;
    word_t w;
    if (!rst_low) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) sz[i] = mq[i].size();
    if (m_locked) begin
      if (sz[m_g] > 0 && out_ready) begin
        w = mq[m_g].pop_front();
        if (w.last) begin
          m_locked = 0;
          if (m_cnt[m_g] < MAXC) m_cnt[m_g]++;
          m_rr = (m_g + 1) % N;
        end
      end
    end else if (m_armed) begin
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!m_locked && sz[c] > 0 && en[c]) begin
          m_locked = 1;
          m_g = c;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_rdy && in_valid[i] && sz[i] < DEPTH) begin
        w.last = in_last[i]; w.keep = in_keep[i*BWB +: BWB]; w.data = in_data[i*BW +: BW];
        mq[i].push_back(w);
      end
    end
    m_armed = m_armed || start;
    m_rdy = 1;
  endtask

  task automatic cycle();
    #1;
    if (!rst_low) model_reset();
    compare();
    @(posedge clk_line);
    model_update();
    @(negedge clk_line);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_word(input int ch, input logic [BW-1:0] d, input bit last, input bit vld);
    in_valid[ch] = vld;
    in_last[ch] = last;
    in_data[ch*BW +: BW] = d;
    in_keep[ch*BWB +: BWB] = '1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout expected=finish", cyc);
    $fatal(1);
  end

  initial begin
    int idx, p, lat;
    bit acc, cleared;
    repeat (2) @(negedge clk_line);

    // reset release
    cycle();
    chk("rst_in_ready_low", in_ready, 4'h0);
    rst_low = 1'b1;
    cycle();
    chk("rel_in_ready_ones", in_ready, 4'hF);

    // arm gate
    hs_log.delete();
    for (int k = 0; k < 3; k++) begin
      set_word(0, 32'hA000_0000 + k, k == 2, 1'b1);
      cycle();
    end
    in_valid = '0; in_last = '0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("gate_no_valid", so.TVALID, 1'b0);
    end
    chk("gate_ready_high", in_ready[0], 1'b1);
    p = cyc;
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(8);
    chk("gate_words", hs_log.size(), 3);
    lat = (hs_log.size() > 0) ? hs_log[0].cyc - p : -1;
    chk("gate_latency", (lat >= 1 && lat <= 2), 1'b1);
    for (int k = 0; k < hs_log.size() && k < 3; k++) begin
      chk("gate_data", hs_log[k].data, 32'hA000_0000 + k);
      chk("gate_dest", hs_log[k].dest, 0);
    end
    chk("gate_cnt0", pkt_cnt[3:0], 4'd1);

    // mid-packet reset
    hs_log.delete();
    for (int k = 0; k < 6 && hs_log.size() == 0; k++) begin
      set_word(0, 32'hB000_0000 + k, k == 2, k < 3);
      cycle();
    end
    chk("rstm_started", hs_log.size(), 1);
    in_valid = '0; in_last = '0;
    rst_low = 1'b0;
    cycle();
    chk("rstm_valid", so.TVALID, 1'b0);
    chk("rstm_data", so.TDATA, 32'h0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_ready", in_ready, 4'h0);
    chk("rstm_cnt", pkt_cnt, 16'h0);
    rst_low = 1'b1;
    cycle();
    chk("rstm_ready_rel", in_ready, 4'hF);
    start = 1'b1;
    cycle();
    start = 1'b0;
    run(4);
    chk("rstm_flushed", hs_log.size(), 1);

    // round-robin fairness
    hs_log.delete();
    for (int k = 0; k < 2; k++) begin
      for (int ch = 0; ch < N; ch++) set_word(ch, 32'hC000_0000 + ch * 16 + k, k == 1, 1'b1);
      cycle();
    end
    in_valid = '0; in_last = '0;
    run(14);
    chk("rr_words", hs_log.size(), 8);
    for (int j = 0; j < hs_log.size() && j < 8; j++) begin
      chk("rr_dest", hs_log[j].dest, j / 2);
      chk("rr_data", hs_log[j].data, 32'hC000_0000 + (j / 2) * 16 + (j % 2));
      if (j > 0) chk("rr_gap", hs_log[j].cyc - hs_log[j-1].cyc, (j % 2 == 1) ? 1 : 2);
    end

    // enable mask, ch1 disabled mid-packet
    hs_log.delete();
    en = 4'b1010;
    cleared = 0;
    for (int t = 0; t < 24; t++) begin
      if (t < 4) begin
        for (int ch = 0; ch < N; ch++) set_word(ch, 32'hE000_0000 + ch * 16 + t, t % 2 == 1, 1'b1);
      end else begin
        in_valid = '0; in_last = '0;
      end
      if (!cleared && so.TVALID && so.TDEST == 2'd1) begin
        en = 4'b1000;
        cleared = 1;
      end
      cycle();
    end
    chk("en_words", hs_log.size(), 6);
    for (int j = 0; j < hs_log.size() && j < 6; j++) begin
      chk("en_dest", hs_log[j].dest, (j < 2) ? 1 : 3);
      chk("en_data", hs_log[j].data, 32'hE000_0000 + ((j < 2) ? 16 + j : 48 + j - 2));
    end
    en = '1;
    run(24);

    // backpressure and full FIFO
    hs_log.delete();
    out_ready = 1'b0;
    idx = 0;
    for (int t = 0; t < 10; t++) begin
      set_word(0, 32'hD000_0000 + idx, idx == 5, idx < 6);
      acc = in_valid[0] && in_ready[0];
      cycle();
      if (acc) idx++;
      if (so.TVALID) chk("bp_hold", so.TDATA, 32'hD000_0000);
    end
    chk("bp_accepted", idx, 4);
    chk("bp_ready_low", in_ready[0], 1'b0);
    chk("bp_valid", so.TVALID, 1'b1);
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      set_word(0, 32'hD000_0000 + idx, idx == 5, idx < 6);
      acc = in_valid[0] && in_ready[0];
      cycle();
      if (acc) idx++;
    end
    chk("bp_words", hs_log.size(), 6);
    for (int j = 0; j < hs_log.size() && j < 6; j++)
      chk("bp_order", hs_log[j].data, 32'hD000_0000 + j);

    // counter saturation
    hs_log.delete();
    idx = 0;
    for (int t = 0; t < 200 && hs_log.size() < 20; t++) begin
      set_word(2, 32'hF000_0000 + idx, 1'b1, idx < 20);
      acc = in_valid[2] && in_ready[2];
      cycle();
      if (acc) idx++;
    end
    in_valid = '0; in_last = '0;
    run(2);
    chk("sat_pkts", hs_log.size(), 20);
    chk("sat_cnt2", pkt_cnt[11:8], 4'hF);

    // randomized traffic with occasional async reset
    for (int t = 0; t < 3000; t++) begin
      for (int ch = 0; ch < N; ch++) begin
        in_valid[ch] = ($urandom_range(0, 2) != 0);
        in_last[ch] = ($urandom_range(0, 2) == 0);
        in_data[ch*BW +: BW] = $urandom();
        in_keep[ch*BWB +: BWB] = BWB'($urandom_range(0, 15));
      end
      start = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) en = N'($urandom_range(0, 15));
      if (!rst_low) rst_low = 1'b1;
      else if ($urandom_range(0, 599) == 0) rst_low = 1'b0;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
